// File: rtl/sr_ff_arb.sv
// rtl/sr_ff_arb.sv - two-requester round-robin arbiter/sequencer for one shared sr_ff flag
// Optional read-back verify with retry: define SR_ARB_VERIFY_EN to compile it in.
module sr_ff_arb #(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic req_a,
    input  logic req_b,
    input  logic op_a,
    input  logic op_b,
    output logic ack_a,
    output logic ack_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic err,
    output logic din_s,
    output logic din_r,
    input  logic dout_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;      // 0 favours A, 1 favours B
    logic   sel_q, sel_d;      // granted requester: 0 = A, 1 = B
    logic   op_q, op_d;        // latched operation: 1 = set, 0 = clear
    logic   gnt_a_q, gnt_a_d;
    logic   gnt_b_q, gnt_b_d;
    logic   ack_a_q, ack_a_d;
    logic   ack_b_q, ack_b_d;
    logic   busy_q, busy_d;
    logic   din_s_q, din_s_d;
    logic   din_r_q, din_r_d;
    logic   pick_b;

`ifdef SR_ARB_VERIFY_EN
    localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);
    logic [3:0] retry_q, retry_d;
    logic [3:0] retry_inc;
    logic       err_q, err_d;

    assign retry_inc = retry_q + 4'd1;
`else
    // Read-back and the retry limit have no meaning without verify.
    logic        unused_dout;
    int unsigned unused_max_retry;

    assign unused_dout      = dout_q;
    assign unused_max_retry = MAX_RETRY;
`endif

    // A wins when alone or when both request and the pointer favours A.
    assign pick_b = req_b & (~req_a | ptr_q);

    // Next-state, latched-request and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        op_d    = op_q;
`ifdef SR_ARB_VERIFY_EN
        retry_d = retry_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    sel_d   = pick_b;
                    op_d    = pick_b ? op_b : op_a;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
`ifdef SR_ARB_VERIFY_EN
                state_d = ST_CHECK;
`else
                state_d = ST_DONE;
`endif
            end
`ifdef SR_ARB_VERIFY_EN
            ST_CHECK: begin
                if (dout_q == op_q) begin
                    state_d = ST_DONE;
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc < MAX_RETRY_W) begin
                        state_d = ST_DRIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
`endif
            ST_DONE: begin
                // Hand priority to the requester that was not just served.
                ptr_d   = ~sel_q;
`ifdef SR_ARB_VERIFY_EN
                retry_d = 4'd0;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered.
        busy_d  = (state_d != ST_IDLE);
        gnt_a_d = busy_d & ~sel_d;
        gnt_b_d = busy_d & sel_d;
        din_s_d = (state_d == ST_DRIVE) & op_d;
        din_r_d = (state_d == ST_DRIVE) & ~op_d;
        ack_a_d = (state_d == ST_DONE) & ~sel_d;
        ack_b_d = (state_d == ST_DONE) & sel_d;
    end

    // State, pointer and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            op_q    <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            busy_q  <= 1'b0;
            din_s_q <= 1'b0;
            din_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            busy_q  <= busy_d;
            din_s_q <= din_s_d;
            din_r_q <= din_r_d;
        end
    end

`ifdef SR_ARB_VERIFY_EN
    // Retry counter and sticky error flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            retry_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign busy  = busy_q;
    assign din_s = din_s_q;
    assign din_r = din_r_q;

    // Driving set and reset together would leave the flag undefined.
    a_no_set_and_reset: assert property (@(posedge clk) disable iff (!n_rst) !(din_s_q && din_r_q));

endmodule
